// File: rtl/mfe_led7seg_bin2seg_formatter_if.sv
// mfe_led7seg_bin2seg_formatter_if: request/response bundle between a value source and the segment formatter.
interface mfe_led7seg_bin2seg_formatter_if #(
    parameter int DIG_NUM   = 8,
    parameter int SEG_NUM   = 8,
    parameter int BIN_WIDTH = 27
);
    logic [BIN_WIDTH-1:0]       bin;
    logic [DIG_NUM-1:0]         dp;
    logic                       blank;
    logic                       in_vld;
    logic                       in_rdy;
    logic [DIG_NUM*SEG_NUM-1:0] dat;
    logic                       vld;
    logic                       ovf;

    modport master (output bin, dp, blank, in_vld, input in_rdy, dat, vld, ovf);
    modport slave  (input bin, dp, blank, in_vld, output in_rdy, dat, vld, ovf);
endinterface

// File: rtl/mfe_led7seg_bin2seg_formatter.sv
// mfe_led7seg_bin2seg_formatter: binary to decimal (double-dabble) and active-low common-anode segment encoding.
module mfe_led7seg_bin2seg_formatter #(
    parameter int DIG_NUM   = 8,
    parameter int SEG_NUM   = 8,
    parameter int BIN_WIDTH = 27
) (
    input logic clk,
    input logic rst,
    mfe_led7seg_bin2seg_formatter_if.slave bus
);
    function automatic int pow10_bits(int n);
        longint v = 1;
        int b = 0;
        for (int i = 0; i < n; i++) v = v * 10;
        while ((64'd1 << b) < v) b++;
        return b;
    endfunction

    localparam int POW_BITS = pow10_bits(DIG_NUM);
    localparam int LIM_W    = BIN_WIDTH > POW_BITS + 1 ? BIN_WIDTH : POW_BITS + 1;
    localparam int BCD_W    = 4 * DIG_NUM;
    localparam int CNT_W    = $clog2(BIN_WIDTH + 1);

    function automatic logic [LIM_W-1:0] pow10(int n);
        logic [LIM_W-1:0] v = 1;
        for (int i = 0; i < n; i++) v = v * LIM_W'(10);
        return v;
    endfunction

    localparam logic [LIM_W-1:0] LIMIT = pow10(DIG_NUM);

    function automatic logic [SEG_NUM-1:0] seg(logic [3:0] n);
        case (n)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE, DONE} state_t;

    state_t                     state;
    logic [BIN_WIDTH-1:0]       shreg;
    logic [BCD_W-1:0]           bcd;
    logic [BCD_W-1:0]           bcd_adj;
    logic [CNT_W-1:0]           cnt;
    logic [DIG_NUM-1:0]         dp_q;
    logic                       blank_q;
    logic                       ovf_next;
    logic [DIG_NUM*SEG_NUM-1:0] staging;
    logic [DIG_NUM*SEG_NUM-1:0] pattern;
    logic [LIM_W-1:0]           bin_ext;
    logic [3:0]                 nib;
    logic [SEG_NUM-1:0]         code;
    logic                       nz;

    assign bin_ext = LIM_W'(bus.bin);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIG_NUM; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Walk from the top digit down so nz marks "at or below the most significant nonzero digit".
    always_comb begin
        pattern = '0;
        nz      = 1'b0;
        nib     = '0;
        code    = '1;
        for (int i = DIG_NUM - 1; i >= 0; i--) begin
            nib  = bcd[4*i +: 4];
            nz   = nz | (nib != 4'd0);
            code = ovf_next ? 8'hBF : (blank_q && !nz && i != 0) ? 8'hFF : seg(nib);
            if (!ovf_next && dp_q[i]) code[SEG_NUM-1] = 1'b0;
            pattern[SEG_NUM*i +: SEG_NUM] = code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.in_rdy <= 1'b1;
            bus.vld    <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.dat    <= '1;
        end else begin
            case (state)
                IDLE: begin
                    bus.vld    <= 1'b0;
                    bus.in_rdy <= 1'b1;
                    if (bus.in_rdy && bus.in_vld) begin
                        shreg      <= bus.bin;
                        dp_q       <= bus.dp;
                        blank_q    <= bus.blank;
                        bcd        <= '0;
                        ovf_next   <= bin_ext >= LIMIT;
                        cnt        <= CNT_W'(BIN_WIDTH);
                        bus.in_rdy <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, shreg} <= {bcd_adj, shreg} << 1;
                    cnt          <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= ENCODE;
                end
                ENCODE: begin
                    staging <= pattern;
                    state   <= DONE;
                end
                default: begin
                    bus.dat <= staging;
                    bus.ovf <= ovf_next;
                    bus.vld <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mfe_led7seg_bin2seg_formatter.sv
// tb_mfe_led7seg_bin2seg_formatter: directed vectors into a scoreboard, checked by a monitor on vld.
module tb_mfe_led7seg_bin2seg_formatter;
    typedef struct {
        logic [63:0] dat;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vld = 0;
    int   n_exp = 0;
    logic prev_vld = 1'b0;
    exp_t sb[$];

    mfe_led7seg_bin2seg_formatter_if #(.DIG_NUM(8), .SEG_NUM(8), .BIN_WIDTH(27)) bus ();

    mfe_led7seg_bin2seg_formatter #(.DIG_NUM(8), .SEG_NUM(8), .BIN_WIDTH(27)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (prev_vld) begin
            check("rdy_after_vld", 64'(bus.in_rdy), 64'd1);
            check("vld_one_cycle", 64'(bus.vld), 64'd0);
        end
        if (bus.vld) begin
            n_vld++;
            if (sb.size() == 0) check("unexpected_vld", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("dat", bus.dat, e.dat);
                check("ovf", 64'(bus.ovf), 64'(e.ovf));
                check("latency", 64'(cyc - e.acc), 64'd29);
            end
        end
        prev_vld = bus.vld;
    end

    task automatic send(input logic [26:0] b, input logic [7:0] d, input logic bl,
                        input logic [63:0] ed, input logic eo, input bit push);
        int t = 0;
        @(negedge clk);
        while (!bus.in_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_rdy) begin
            check("send_timeout", 64'd1, 64'd0);
            return;
        end
        bus.bin    = b;
        bus.dp     = d;
        bus.blank  = bl;
        bus.in_vld = 1'b1;
        if (push) begin
            sb.push_back('{ed, eo, cyc + 1});
            n_exp++;
        end
        @(negedge clk);
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !bus.in_rdy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || !bus.in_rdy) check("idle_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        bus.bin    = '0;
        bus.dp     = '0;
        bus.blank  = 1'b0;
        bus.in_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dat", bus.dat, 64'hFFFFFFFFFFFFFFFF);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_rdy", 64'(bus.in_rdy), 64'd1);
        check("rst_vld", 64'(bus.vld), 64'd0);

        send(27'd0,         8'h00, 1'b1, 64'hFFFFFFFFFFFFFFC0, 1'b0, 1'b1);
        wait_idle();
        send(27'd76543210,  8'h00, 1'b0, 64'hF8829299B0A4F9C0, 1'b0, 1'b1);
        wait_idle();
        send(27'd99999999,  8'h00, 1'b0, 64'h9090909090909090, 1'b0, 1'b1);
        wait_idle();
        send(27'd100000000, 8'h00, 1'b0, 64'hBFBFBFBFBFBFBFBF, 1'b1, 1'b1);
        wait_idle();
        send(27'd1234,      8'h04, 1'b1, 64'hFFFFFFFFF924B099, 1'b0, 1'b1);
        wait_idle();
        send(27'd5,         8'h81, 1'b1, 64'h7FFFFFFFFFFFFF12, 1'b0, 1'b1);
        wait_idle();
        send(27'd1000,      8'h00, 1'b1, 64'hFFFFFFFFF9C0C0C0, 1'b0, 1'b1);
        wait_idle();
        send(27'd1000,      8'h00, 1'b0, 64'hC0C0C0C0F9C0C0C0, 1'b0, 1'b1);
        wait_idle();

        // Requests while busy must be dropped.
        send(27'd42, 8'h00, 1'b1, 64'hFFFFFFFFFFFF99A4, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            bus.bin    = 27'($urandom_range(0, 1000));
            bus.in_vld = 1'b1;
            @(negedge clk);
        end
        bus.in_vld = 1'b0;
        wait_idle();

        // Leave ovf set, then reset mid-conversion.
        send(27'h7FFFFFF, 8'hFF, 1'b0, 64'hBFBFBFBFBFBFBFBF, 1'b1, 1'b1);
        wait_idle();
        send(27'd12345, 8'h00, 1'b0, 64'h0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_dat", bus.dat, 64'hFFFFFFFFFFFFFFFF);
        check("mid_rst_ovf", 64'(bus.ovf), 64'd0);
        check("mid_rst_rdy", 64'(bus.in_rdy), 64'd1);
        repeat (40) @(negedge clk);
        send(27'd8, 8'h00, 1'b0, 64'hC0C0C0C0C0C0C080, 1'b0, 1'b1);
        wait_idle();

        check("vld_count", 64'(n_vld), 64'(n_exp));
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
